// File: rtl/hist_equalizer.sv
`default_nettype none
// ============================================================================
// Module   : hist_equalizer
// Brief    : Accumulates a per-bin histogram stream into a CDF, derives a
//            histogram-equalisation LUT with a restoring divider (one
//            quotient bit per cycle), and remaps a pixel stream through the
//            LUT with one cycle of latency. Pixels bypass until a LUT exists.
// Revision : 1.0 - initial release
// ============================================================================
module hist_equalizer #(
    parameter int DATA_WIDTH = 8,
    parameter int HIST_BINS  = 256,
    parameter int HIST_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hist_valid,
    input  logic [DATA_WIDTH-1:0] hist_bin,
    input  logic [HIST_WIDTH-1:0] hist_value,
    input  logic                  abort,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  lut_ready,
    output logic                  busy,
    output logic                  seq_err,
    output logic [1:0]            state_out
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_CALC  = 2'd2;
    localparam logic [1:0] c_APPLY = 2'd3;

    // Numerator width: CDF difference times (HIST_BINS-1) plus rounding term.
    localparam int                    c_NUM_W     = HIST_WIDTH + DATA_WIDTH + 1;
    localparam int                    c_STEP_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] c_LAST_BIN  = DATA_WIDTH'(HIST_BINS - 1);
    localparam logic [c_STEP_W-1:0]   c_LAST_STEP = c_STEP_W'(DATA_WIDTH);
    localparam logic [c_NUM_W-1:0]    c_SCALE     = c_NUM_W'(HIST_BINS - 1);

    // Storage: running CDF per bin, and the equalisation LUT.
    logic [HIST_WIDTH-1:0] cdf_mem [HIST_BINS];
    logic [DATA_WIDTH-1:0] lut_mem [HIST_BINS];

    logic [1:0]            state_q,     state_d;
    logic                  lut_ready_q, lut_ready_d;
    logic                  seq_err_q,   seq_err_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [HIST_WIDTH-1:0] cdf_q,       cdf_d;
    logic [HIST_WIDTH-1:0] cdf_min_q,   cdf_min_d;
    logic                  min_found_q, min_found_d;
    logic [HIST_WIDTH-1:0] total_q,     total_d;
    logic [DATA_WIDTH-1:0] exp_bin_q,   exp_bin_d;
    logic [DATA_WIDTH-1:0] calc_bin_q,  calc_bin_d;
    logic [c_STEP_W-1:0]   step_q,      step_d;
    logic [c_NUM_W-1:0]    rem_q,       rem_d;
    logic [c_NUM_W-1:0]    dsh_q,       dsh_d;
    logic [DATA_WIDTH-1:0] quo_q,       quo_d;

    logic [HIST_WIDTH:0]   w_sum;
    logic [HIST_WIDTH-1:0] w_sum_sat;
    logic [HIST_WIDTH-1:0] w_den;
    logic [HIST_WIDTH-1:0] w_cdf_rd;
    logic [HIST_WIDTH-1:0] w_diff;
    logic [c_NUM_W-1:0]    w_num;
    logic [c_NUM_W-1:0]    w_dsh_init;
    logic                  w_ge;
    logic [c_NUM_W-1:0]    w_rem_next;
    logic [DATA_WIDTH-1:0] w_quo_next;
    logic                  w_cdf_we;
    logic [HIST_WIDTH-1:0] w_cdf_wdata;
    logic                  w_lut_we;
    logic [DATA_WIDTH-1:0] w_lut_wdata;

    // Datapath: saturating CDF adder, numerator/denominator and one divider step.
    always_comb begin
        w_sum      = {1'b0, cdf_q} + {1'b0, hist_value};
        w_sum_sat  = w_sum[HIST_WIDTH] ? {HIST_WIDTH{1'b1}} : w_sum[HIST_WIDTH-1:0];
        w_den      = total_q - cdf_min_q;
        w_cdf_rd   = cdf_mem[calc_bin_q];
        w_diff     = w_cdf_rd - cdf_min_q;
        w_num      = '0;
        if (w_cdf_rd > cdf_min_q) begin
            w_num = c_NUM_W'(w_diff) * c_SCALE + c_NUM_W'(w_den >> 1);
        end
        // Quotient fits in DATA_WIDTH bits, so the divisor starts at its top bit weight.
        w_dsh_init = c_NUM_W'(w_den) << (DATA_WIDTH - 1);
        w_ge       = (rem_q >= dsh_q);
        w_rem_next = w_ge ? (rem_q - dsh_q) : rem_q;
        w_quo_next = {quo_q[DATA_WIDTH-2:0], w_ge};
    end

    // Control FSM: histogram load, LUT calculation, and apply/restart handling.
    always_comb begin
        state_d     = state_q;
        lut_ready_d = lut_ready_q;
        seq_err_d   = seq_err_q;
        cdf_d       = cdf_q;
        cdf_min_d   = cdf_min_q;
        min_found_d = min_found_q;
        total_d     = total_q;
        exp_bin_d   = exp_bin_q;
        calc_bin_d  = calc_bin_q;
        step_d      = step_q;
        rem_d       = rem_q;
        dsh_d       = dsh_q;
        quo_d       = quo_q;
        w_cdf_we    = 1'b0;
        w_cdf_wdata = w_sum_sat;
        w_lut_we    = 1'b0;
        w_lut_wdata = w_quo_next;

        if (abort) begin
            state_d     = c_IDLE;
            lut_ready_d = 1'b0;
            seq_err_d   = 1'b0;
        end else begin
            case (state_q)
                c_IDLE, c_APPLY: begin
                    // Bin 0 is consumed in the same cycle that LOAD is entered.
                    if (hist_valid && (hist_bin == '0)) begin
                        state_d     = c_LOAD;
                        lut_ready_d = 1'b0;
                        cdf_d       = hist_value;
                        cdf_min_d   = hist_value;
                        min_found_d = (hist_value != '0);
                        exp_bin_d   = DATA_WIDTH'(1);
                        w_cdf_we    = 1'b1;
                        w_cdf_wdata = hist_value;
                    end
                end
                c_LOAD: begin
                    if (hist_valid) begin
                        if (hist_bin == exp_bin_q) begin
                            w_cdf_we  = 1'b1;
                            cdf_d     = w_sum_sat;
                            exp_bin_d = exp_bin_q + 1'b1;
                            if (!min_found_q && (w_sum_sat != '0)) begin
                                cdf_min_d   = w_sum_sat;
                                min_found_d = 1'b1;
                            end
                            if (hist_bin == c_LAST_BIN) begin
                                total_d    = w_sum_sat;
                                state_d    = c_CALC;
                                calc_bin_d = '0;
                                step_d     = '0;
                            end
                        end else begin
                            seq_err_d = 1'b1;
                            state_d   = c_IDLE;
                        end
                    end
                end
                c_CALC: begin
                    if (step_q == '0) begin
                        rem_d  = w_num;
                        dsh_d  = w_dsh_init;
                        quo_d  = '0;
                        step_d = c_STEP_W'(1);
                    end else begin
                        rem_d = w_rem_next;
                        dsh_d = dsh_q >> 1;
                        quo_d = w_quo_next;
                        if (step_q == c_LAST_STEP) begin
                            // Degenerate histogram (single occupied bin): identity mapping.
                            w_lut_we    = 1'b1;
                            w_lut_wdata = (w_den == '0) ? calc_bin_q : w_quo_next;
                            step_d      = '0;
                            calc_bin_d  = calc_bin_q + 1'b1;
                            if (calc_bin_q == c_LAST_BIN) begin
                                state_d     = c_APPLY;
                                lut_ready_d = 1'b1;
                            end
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end
                default: state_d = c_IDLE;
            endcase
        end
    end

    // Pixel path: one-cycle remap (or bypass); data holds when no pixel arrives.
    always_comb begin
        out_valid_d = pix_valid;
        out_data_d  = out_data_q;
        if (pix_valid) begin
            out_data_d = lut_ready_q ? lut_mem[pix_data] : pix_data;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= c_IDLE;
            lut_ready_q <= 1'b0;
            seq_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cdf_q       <= '0;
            cdf_min_q   <= '0;
            min_found_q <= 1'b0;
            total_q     <= '0;
            exp_bin_q   <= '0;
            calc_bin_q  <= '0;
            step_q      <= '0;
            rem_q       <= '0;
            dsh_q       <= '0;
            quo_q       <= '0;
        end else begin
            state_q     <= state_d;
            lut_ready_q <= lut_ready_d;
            seq_err_q   <= seq_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cdf_q       <= cdf_d;
            cdf_min_q   <= cdf_min_d;
            min_found_q <= min_found_d;
            total_q     <= total_d;
            exp_bin_q   <= exp_bin_d;
            calc_bin_q  <= calc_bin_d;
            step_q      <= step_d;
            rem_q       <= rem_d;
            dsh_q       <= dsh_d;
            quo_q       <= quo_d;
        end
    end

    // CDF and LUT storage writes; contents are not reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_cdf_we) begin
            cdf_mem[hist_bin] <= w_cdf_wdata;
        end
        if (rst_n && w_lut_we) begin
            lut_mem[calc_bin_q] <= w_lut_wdata;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign lut_ready = lut_ready_q;
    assign seq_err   = seq_err_q;
    assign state_out = state_q;
    assign busy      = (state_q == c_LOAD) || (state_q == c_CALC);

endmodule
`default_nettype wire

// File: tb/tb_hist_equalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hist_equalizer
// Brief    : Self-checking bench for hist_equalizer with a reference LUT model
//            computed from prefix sums and integer division.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hist_equalizer;

    localparam int  DATA_WIDTH = 8;
    localparam int  HIST_BINS  = 256;
    localparam int  HIST_WIDTH = 18;
    localparam longint SAT     = (64'd1 << HIST_WIDTH) - 1;
    localparam int  CALC_CYC   = HIST_BINS * (DATA_WIDTH + 1);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  hist_valid;
    logic [DATA_WIDTH-1:0] hist_bin;
    logic [HIST_WIDTH-1:0] hist_value;
    logic                  abort;
    logic                  pix_valid;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  lut_ready;
    logic                  busy;
    logic                  seq_err;
    logic [1:0]            state_out;

    hist_equalizer #(
        .DATA_WIDTH (DATA_WIDTH),
        .HIST_BINS  (HIST_BINS),
        .HIST_WIDTH (HIST_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hist_valid (hist_valid),
        .hist_bin   (hist_bin),
        .hist_value (hist_value),
        .abort      (abort),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .lut_ready  (lut_ready),
        .busy       (busy),
        .seq_err    (seq_err),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint hist    [HIST_BINS];
    longint exp_lut [HIST_BINS];
    bit     model_ready = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference: saturating prefix sums, first nonzero CDF, rounded scaled quotient.
    task automatic build_model();
        longint cm [HIST_BINS];
        longint cdf, cmin, den;
        bit     found;
        cdf = 0; cmin = 0; found = 0;
        for (int b = 0; b < HIST_BINS; b++) begin
            cdf += hist[b];
            if (cdf > SAT) cdf = SAT;
            cm[b] = cdf;
            if (!found && cdf != 0) begin cmin = cdf; found = 1; end
        end
        den = cdf - cmin;
        for (int b = 0; b < HIST_BINS; b++) begin
            if (den == 0)           exp_lut[b] = b;
            else if (cm[b] <= cmin) exp_lut[b] = 0;
            else exp_lut[b] = ((cm[b] - cmin) * (HIST_BINS - 1) + den / 2) / den;
        end
    endtask

    task automatic send_hist(input bit gaps);
        for (int b = 0; b < HIST_BINS; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                hist_valid = 1'b0;
                tick();
            end
            hist_valid = 1'b1;
            hist_bin   = DATA_WIDTH'(b);
            hist_value = HIST_WIDTH'(hist[b]);
            tick();
        end
        hist_valid = 1'b0;
        check("enter_calc_state", state_out, 2);
        check("enter_calc_busy", busy, 1);
    endtask

    task automatic wait_calc();
        int n = 0;
        while (state_out == 2'd2 && n < 5000) begin
            tick();
            n++;
        end
        check("calc_cycles", n, CALC_CYC);
        check("calc_done_ready", lut_ready, 1);
        check("calc_done_state", state_out, 3);
        check("calc_done_busy", busy, 0);
        model_ready = 1;
    endtask

    task automatic pix(input int p, input longint exp, input string tag);
        pix_valid = 1'b1;
        pix_data  = DATA_WIDTH'(p);
        tick();
        pix_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, exp);
        tick();
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_hold"}, out_data, exp);
    endtask

    task automatic sweep(input string tag);
        for (int p = 0; p < HIST_BINS; p++) begin
            pix_valid = 1'b1;
            pix_data  = DATA_WIDTH'(p);
            tick();
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_lut"}, out_data, model_ready ? exp_lut[p] : p);
        end
        pix_valid = 1'b0;
    endtask

    task automatic fill_uniform();
        for (int b = 0; b < HIST_BINS; b++) hist[b] = 4;
    endtask

    initial begin
        rst_n = 1'b0; hist_valid = 1'b0; hist_bin = '0; hist_value = '0;
        abort = 1'b0; pix_valid = 1'b0; pix_data = '0;
        tick(); tick();
        check("rst_state", state_out, 0);
        check("rst_ready", lut_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        tick();

        // Bypass before any LUT exists.
        pix(8'h12, 8'h12, "bypass_12");
        pix(8'hEE, 8'hEE, "bypass_ee");

        // Non-zero bin in IDLE is ignored; abort beats a bin-0 arrival.
        hist_valid = 1'b1; hist_bin = 8'd5; hist_value = 18'd7;
        tick();
        check("idle_ignore_bin5", state_out, 0);
        hist_bin = 8'd0; abort = 1'b1;
        tick();
        abort = 1'b0; hist_valid = 1'b0;
        check("abort_priority", state_out, 0);

        // Uniform histogram -> identity LUT.
        fill_uniform();
        build_model();
        send_hist(1'b0);
        wait_calc();
        pix(0, 0, "uni_0");
        pix(77, 77, "uni_77");
        pix(255, 255, "uni_255");
        sweep("uni_sweep");

        // New bin 0 in APPLY drops lut_ready with the state change.
        hist_valid = 1'b1; hist_bin = 8'd0; hist_value = 18'd4;
        tick();
        hist_valid = 1'b0;
        check("apply_restart_state", state_out, 1);
        check("apply_restart_ready", lut_ready, 0);
        check("apply_restart_busy", busy, 1);
        model_ready = 0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("load_abort_state", state_out, 0);
        check("load_abort_busy", busy, 0);

        // Two-level histogram.
        for (int b = 0; b < HIST_BINS; b++) hist[b] = 0;
        hist[10] = 100; hist[200] = 300;
        build_model();
        send_hist(1'b1);
        wait_calc();
        pix(150, 0, "two_150");
        pix(210, 255, "two_210");
        sweep("two_sweep");

        // Single occupied bin -> identity.
        for (int b = 0; b < HIST_BINS; b++) hist[b] = 0;
        hist[42] = 1000;
        build_model();
        send_hist(1'b0);
        wait_calc();
        pix(5, 5, "single_5");
        sweep("single_sweep");

        // Sequence error: bins 0, 1, 3.
        hist_valid = 1'b1; hist_value = 18'd9;
        hist_bin = 8'd0; tick();
        hist_bin = 8'd1; tick();
        hist_bin = 8'd3; tick();
        hist_valid = 1'b0;
        model_ready = 0;
        check("seq_err_flag", seq_err, 1);
        check("seq_err_state", state_out, 0);
        check("seq_err_ready", lut_ready, 0);
        pix(8'h5A, 8'h5A, "seq_bypass");
        hist_valid = 1'b1; hist_bin = 8'd0;
        tick();
        hist_valid = 1'b0;
        check("seq_err_new_load", state_out, 1);
        check("seq_err_sticky", seq_err, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("seq_err_abort_clr", seq_err, 0);

        // Abort mid-CALC, then rebuild.
        fill_uniform();
        build_model();
        send_hist(1'b0);
        repeat ($urandom_range(1, 2000)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        model_ready = 0;
        check("calc_abort_state", state_out, 0);
        check("calc_abort_busy", busy, 0);
        check("calc_abort_ready", lut_ready, 0);
        pix(8'h33, 8'h33, "calc_abort_bypass");
        send_hist(1'b1);
        wait_calc();
        pix(77, 77, "rebuild1_77");

        // Reset mid-CALC, then rebuild.
        send_hist(1'b0);
        repeat ($urandom_range(1, 2000)) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_ready = 0;
        check("calc_rst_state", state_out, 0);
        check("calc_rst_busy", busy, 0);
        check("calc_rst_ready", lut_ready, 0);
        check("calc_rst_out_valid", out_valid, 0);
        send_hist(1'b1);
        wait_calc();
        sweep("rebuild2_sweep");

        // Randomized histograms: dense, saturating, sparse.
        for (int t = 0; t < 3; t++) begin
            for (int b = 0; b < HIST_BINS; b++) begin
                case (t)
                    0: hist[b] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 5000);
                    1: hist[b] = $urandom_range(0, 40000);
                    default: hist[b] = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3000) : 0;
                endcase
            end
            build_model();
            send_hist(1'b1);
            wait_calc();
            sweep("rand_sweep");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
